// File: rtl/ram_responder.sv
// Word-addressed RAM that answers DataPath requests with a four-phase mem_done handshake.
// Optional wait states are enabled with the RAM_WAIT_EN macro.
module ram_responder #(
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  Read,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_done,
    output logic                  busy
);

    localparam int unsigned Depth = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  wr_q;
    logic                  accept;
    logic                  access;
    logic                  wait_done;

    logic [DATA_WIDTH-1:0] mem [Depth];

    assign accept = (state_q == StIdle) && (Read || Write);

`ifdef RAM_WAIT_EN
    localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

    logic [3:0] cnt_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= WaitLoad;
        end else if (state_q == StBusy && cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
        end
    end

    assign wait_done = (cnt_q == 4'd0);
`else
    localparam int unsigned unused_wait_cycles = WAIT_CYCLES;

    assign wait_done = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        access  = 1'b0;
        unique case (state_q)
            StIdle: if (Read || Write) state_d = StBusy;
            StBusy: begin
                if (wait_done) begin
                    access  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone: if (!Read && !Write) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= StIdle;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            Mdatain <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q <= address;
                data_q <= data_in;
                // Write has priority when both strobes are high.
                wr_q   <= Write;
            end
            if (access && !wr_q) begin
                Mdatain <= mem[addr_q];
            end
        end
    end

    // Array is never reset; a clear forces StIdle, so no commit can follow an abort.
    always_ff @(posedge clock) begin
        if (access && wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign mem_done = (state_q == StDone);
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: stimulus pushes expected Mdatain per access,
// a negedge monitor pops and compares on each mem_done rise.
module tb_ram_responder;

    localparam int AW = 9;
    localparam int DW = 32;
`ifdef RAM_WAIT_EN
    localparam int W = 3;
`else
    localparam int W = 0;
`endif

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_in = '0;
    logic          Read = 1'b0;
    logic          Write = 1'b0;
    logic [DW-1:0] Mdatain;
    logic          mem_done;
    logic          busy;

    ram_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .WAIT_CYCLES(3)
    ) dut (
        .clock   (clock),
        .clear   (clear),
        .address (address),
        .data_in (data_in),
        .Read    (Read),
        .Write   (Write),
        .Mdatain (Mdatain),
        .mem_done(mem_done),
        .busy    (busy)
    );

    always #5 clock = ~clock;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] model[int];
    logic [DW-1:0] exp_mdat = '0;
    logic          prev_done = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (mem_done && !prev_done) begin
            if (exp_q.size() == 0) check("done_without_request", 32'(exp_q.size()), 32'd1);
            else check("mdatain_at_done", Mdatain, exp_q.pop_front());
        end
        prev_done = mem_done;
    end

    // One full handshake; hold > 0 keeps the strobe high that many cycles after mem_done.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input bit late, input int hold);
        int lat;
        @(negedge clock);
        Read    = rd;
        Write   = wr;
        address = addr;
        data_in = data;
        if (wr) model[int'(addr)] = data;
        else exp_mdat = model[int'(addr)];
        exp_q.push_back(exp_mdat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
            if (lat == 1 && late) begin
                address = ~addr;
                data_in = ~data;
            end
        end while (!mem_done && lat < 40);
        check({name, "_latency"}, 32'(lat), 32'(W + 2));
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            check({name, "_held_done"}, 32'(mem_done), 32'd1);
        end
        Read  = 1'b0;
        Write = 1'b0;
        @(negedge clock);
        check({name, "_release_done"}, 32'(mem_done), 32'd0);
        check({name, "_release_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        check("reset_mdatain", Mdatain, 32'h0);
        check("reset_done", 32'(mem_done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        clear = 1'b0;

        // Write then read back
        do_access("wr7", 1'b0, 1'b1, 9'd7, 32'h4A1B8000, 1'b0, 0);
        do_access("rd7", 1'b1, 1'b0, 9'd7, 32'h0, 1'b0, 0);
        check("readback7", Mdatain, 32'h4A1B8000);

        // Held read strobe: one access only, mem_done stays high
        do_access("rd7_held", 1'b1, 1'b0, 9'd7, 32'h0, 1'b0, 10);
        check("held_mdatain", Mdatain, 32'h4A1B8000);

        // Simultaneous strobes: write wins, Mdatain untouched
        do_access("wr3", 1'b0, 1'b1, 9'd3, 32'h12, 1'b0, 0);
        do_access("wr4", 1'b0, 1'b1, 9'd4, 32'h7F, 1'b0, 0);
        do_access("rd4", 1'b1, 1'b0, 9'd4, 32'h0, 1'b0, 0);
        do_access("rw3", 1'b1, 1'b1, 9'd3, 32'h01, 1'b0, 0);
        check("rw_keeps_mdatain", Mdatain, 32'h7F);
        do_access("rd3", 1'b1, 1'b0, 9'd3, 32'h0, 1'b0, 0);
        check("rw_wrote_mem3", Mdatain, 32'h01);

        // Reset during a write aborts it
        do_access("wr5", 1'b0, 1'b1, 9'd5, 32'h12, 1'b0, 0);
        @(negedge clock);
        Write   = 1'b1;
        address = 9'd5;
        data_in = 32'hFFFFFFFF;
        @(negedge clock);
        check("abort_busy_before", 32'(busy), 32'd1);
        clear = 1'b1;
        #1;
        check("abort_mdatain", Mdatain, 32'h0);
        check("abort_done", 32'(mem_done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_mdat = '0;
        @(negedge clock);
        Write = 1'b0;
        clear = 1'b0;
        do_access("rd5", 1'b1, 1'b0, 9'd5, 32'h0, 1'b0, 0);
        check("abort_mem5", Mdatain, 32'h12);

        // Late address/data change after acceptance is ignored
        do_access("wr10", 1'b0, 1'b1, 9'd10, 32'hCAFE0010, 1'b0, 0);
        do_access("wr9_late", 1'b0, 1'b1, 9'd9, 32'hA5A55A5A, 1'b1, 0);
        do_access("rd9", 1'b1, 1'b0, 9'd9, 32'h0, 1'b0, 0);
        check("late_mem9", Mdatain, 32'hA5A55A5A);
        do_access("rd10_late", 1'b1, 1'b0, 9'd10, 32'h0, 1'b1, 0);
        check("late_mem10", Mdatain, 32'hCAFE0010);

        repeat (2) @(negedge clock);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
